assoc_key_value_store: RTL and testbench

- Parametrised set-associative successor to the direct-mapped 1-cycle key/value store.
- Used for BTB- and predictor-style lookups.
- Adds WAYS-way associativity, per-set round-robin replacement, single-key invalidate and a multi-cycle flush FSM with ready/busy handshake.
- Lookup latency stays fixed at 1 cycle.

---
 rtl/assoc_key_value_store.sv | 270 +++++++++++++++++++++++++++
 tb/tb_assoc_key_value_store.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_key_value_store.sv
// ---------------------------------------------------------------------------
// assoc_key_value_store
//
// Set-associative key/value store for BTB- and predictor-style lookups.
// The set index is key[INDEX_WIDTH-1:0] and the whole key is stored as the
// tag. Each set holds WAYS entries. When a set is full, a per-set
// round-robin victim pointer picks the way to replace. A lookup returns its
// result exactly one cycle after it is accepted. A full flush walks through
// one set per cycle. While the flush runs, req_ready is low and no lookups,
// updates or invalidates are accepted.
//
// Optional build macro:
//   ASSOC_KVS_BYPASS_EN - a lookup sees the update or invalidate that is
//                         accepted in the same cycle for the same key.
//                         Without the macro, a lookup sees the contents from
//                         before that cycle's writes.
//
// Parameters:
//   KEY_WIDTH   full key width (the stored tag)
//   VAL_WIDTH   value width
//   INDEX_WIDTH set index width; there are 2**INDEX_WIDTH sets
//   WAYS        ways per set (power of two, >= 1)
//   LOG_ENABLE  debug log enable
//   LOG_AS      debug log prefix
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_ready                  high in IDLE: requests/updates accepted
//   req_valid, req_key         lookup request
//   resp_valid                 one-cycle strobe after an accepted lookup
//   resp_hit, resp_value       lookup result (value is 0 on a miss)
//   update_valid/key/value     insert or overwrite
//   inval_valid, inval_key     invalidate a single key
//   flush_valid                start a full flush
//   flush_busy                 flush in progress
// ---------------------------------------------------------------------------
module assoc_key_value_store #(
  parameter int    KEY_WIDTH   = 32,
  parameter int    VAL_WIDTH   = 32,
  parameter int    INDEX_WIDTH = 4,
  parameter int    WAYS        = 2,
  parameter int    LOG_ENABLE  = 0,
  parameter string LOG_AS      = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 req_ready,
  input  logic                 req_valid,
  input  logic [KEY_WIDTH-1:0] req_key,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [VAL_WIDTH-1:0] resp_value,
  input  logic                 update_valid,
  input  logic [KEY_WIDTH-1:0] update_key,
  input  logic [VAL_WIDTH-1:0] update_value,
  input  logic                 inval_valid,
  input  logic [KEY_WIDTH-1:0] inval_key,
  input  logic                 flush_valid,
  output logic                 flush_busy
);

  localparam int SETS  = 1 << INDEX_WIDTH;
  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  if (INDEX_WIDTH < 1 || INDEX_WIDTH > KEY_WIDTH || WAYS < 1 ||
      (WAYS & (WAYS - 1)) != 0 || (LOG_ENABLE != 0 && LOG_ENABLE != 1))
  begin : g_param_check
    $error("%s assoc_key_value_store: illegal parameter set", LOG_AS);
  end

  typedef enum logic [0:0] {ST_IDLE, ST_FLUSH} state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  // Storage. Only the valid bits and victim pointers are reset.
  logic [KEY_WIDTH-1:0] key_mem  [SETS][WAYS];
  logic [VAL_WIDTH-1:0] val_mem  [SETS][WAYS];
  logic [WAYS-1:0]      valid_q  [SETS];
  logic [PTR_W-1:0]     victim_q [SETS];

  logic [INDEX_WIDTH-1:0] req_set, upd_set, inv_set;
  assign req_set = req_key[INDEX_WIDTH-1:0];
  assign upd_set = update_key[INDEX_WIDTH-1:0];
  assign inv_set = inval_key[INDEX_WIDTH-1:0];

  logic idle, req_fire, upd_fire, inv_fire;
  assign idle     = (state_q == ST_IDLE);
  assign req_fire = req_valid    & idle;
  assign upd_fire = update_valid & idle;
  assign inv_fire = inval_valid  & idle;

  // ---------------------------------------------------------------------
  // Flush FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
    end else begin
      // NOTE: all clocked state uses non-blocking assignments. Every register
      // then updates from the values present before the edge, whatever order
      // the always blocks run in.
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first. That way no path
    // leaves a signal unassigned, and no latch is inferred.
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    req_ready   = 1'b0;
    flush_busy  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (flush_valid) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
        end
      end
      ST_FLUSH: begin
        flush_busy  = 1'b1;
        flush_cnt_d = flush_cnt_q + 1'b1;
        // The last set is being cleared in this cycle.
        if (flush_cnt_q == '1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Lookup against the contents from before this cycle's writes
  // ---------------------------------------------------------------------
  logic                 lk_hit;
  logic [VAL_WIDTH-1:0] lk_val;

  always_comb begin
    lk_hit = 1'b0;
    lk_val = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_set][w] && key_mem[req_set][w] == req_key) begin
        lk_hit = 1'b1;
        lk_val = val_mem[req_set][w];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Update way selection: matching way, else lowest invalid way, else victim
  // ---------------------------------------------------------------------
  logic             upd_match, upd_free, upd_evict;
  logic [PTR_W-1:0] upd_match_way, upd_free_way, upd_way, victim_next;

  always_comb begin
    upd_match     = 1'b0;
    upd_match_way = '0;
    upd_free      = 1'b0;
    upd_free_way  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[upd_set][w] && key_mem[upd_set][w] == update_key) begin
        upd_match     = 1'b1;
        upd_match_way = PTR_W'(w);
      end
    end
    // Scan from the top down so that the lowest-numbered invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[upd_set][w]) begin
        upd_free     = 1'b1;
        upd_free_way = PTR_W'(w);
      end
    end
    upd_evict = 1'b0;
    if (upd_match)     upd_way = upd_match_way;
    else if (upd_free) upd_way = upd_free_way;
    else begin
      upd_way   = victim_q[upd_set];
      upd_evict = 1'b1;
    end
    victim_next = (victim_q[upd_set] == PTR_W'(WAYS - 1)) ? '0
                                                           : victim_q[upd_set] + 1'b1;
  end

  // ---------------------------------------------------------------------
  // Invalidate match
  // ---------------------------------------------------------------------
  logic             inv_match;
  logic [PTR_W-1:0] inv_way;

  always_comb begin
    inv_match = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[inv_set][w] && key_mem[inv_set][w] == inval_key) begin
        inv_match = 1'b1;
        inv_way   = PTR_W'(w);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Valid bits and victim pointers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s]  <= '0;
        victim_q[s] <= '0;
      end
    end else if (state_q == ST_FLUSH) begin
      valid_q[flush_cnt_q] <= '0;
    end else begin
      if (inv_fire && inv_match) valid_q[inv_set][inv_way] <= 1'b0;
      // This assignment comes later in the block, so when the update and the
      // invalidate hit the same entry, the update wins.
      if (upd_fire) begin
        valid_q[upd_set][upd_way] <= 1'b1;
        if (upd_evict) victim_q[upd_set] <= victim_next;
      end
    end
  end

  // NOTE: the key and value arrays have no reset. The valid bits say which
  // entries mean anything, and leaving the reset off keeps these arrays
  // mappable to RAM.
  always_ff @(posedge clk) begin
    if (upd_fire) begin
      key_mem[upd_set][upd_way] <= update_key;
      val_mem[upd_set][upd_way] <= update_value;
    end
  end

  // ---------------------------------------------------------------------
  // Response
  // ---------------------------------------------------------------------
  logic                 rsp_hit_d;
  logic [VAL_WIDTH-1:0] rsp_val_d;

  always_comb begin
    rsp_hit_d = lk_hit;
    rsp_val_d = lk_val;
`ifdef ASSOC_KVS_BYPASS_EN
    if (upd_fire && update_key == req_key) begin
      rsp_hit_d = 1'b1;
      rsp_val_d = update_value;
    end else if (inv_fire && inval_key == req_key) begin
      rsp_hit_d = 1'b0;
      rsp_val_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_value <= '0;
    end else begin
      resp_valid <= req_fire;
      // Without an accepted lookup, hit and value keep their last result.
      if (req_fire) begin
        resp_hit   <= rsp_hit_d;
        resp_value <= rsp_val_d;
      end
    end
  end

endmodule

// File: tb/tb_assoc_key_value_store.sv
// ---------------------------------------------------------------------------
// tb_assoc_key_value_store
//
// Directed bench for assoc_key_value_store with INDEX_WIDTH=2 and WAYS=2.
// It covers lookup hit and miss, round-robin eviction, overwrite, use of an
// invalid way, invalidate, flush timing, same-cycle update/invalidate/lookup
// interaction (both with and without ASSOC_KVS_BYPASS_EN), and reset in the
// middle of a flush.
// ---------------------------------------------------------------------------
module tb_assoc_key_value_store;

  localparam int KW = 32;
  localparam int VW = 32;

`ifdef ASSOC_KVS_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req_ready;
  logic          req_valid;
  logic [KW-1:0] req_key;
  logic          resp_valid;
  logic          resp_hit;
  logic [VW-1:0] resp_value;
  logic          update_valid;
  logic [KW-1:0] update_key;
  logic [VW-1:0] update_value;
  logic          inval_valid;
  logic [KW-1:0] inval_key;
  logic          flush_valid;
  logic          flush_busy;

  assoc_key_value_store #(
    .KEY_WIDTH  (KW),
    .VAL_WIDTH  (VW),
    .INDEX_WIDTH(2),
    .WAYS       (2),
    .LOG_ENABLE (0),
    .LOG_AS     ("kvs")
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_ready   (req_ready),
    .req_valid   (req_valid),
    .req_key     (req_key),
    .resp_valid  (resp_valid),
    .resp_hit    (resp_hit),
    .resp_value  (resp_value),
    .update_valid(update_valid),
    .update_key  (update_key),
    .update_value(update_value),
    .inval_valid (inval_valid),
    .inval_key   (inval_key),
    .flush_valid (flush_valid),
    .flush_busy  (flush_busy)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [KW-1:0] k, input logic [VW-1:0] v);
    update_valid = 1'b1;
    update_key   = k;
    update_value = v;
    tick();
    update_valid = 1'b0;
  endtask

  task automatic do_inval(input logic [KW-1:0] k);
    inval_valid = 1'b1;
    inval_key   = k;
    tick();
    inval_valid = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [KW-1:0] k,
                        input logic exp_hit, input logic [VW-1:0] exp_val);
    req_valid = 1'b1;
    req_key   = k;
    tick();
    req_valid = 1'b0;
    check({tag, ".valid"}, 32'(resp_valid), 32'd1);
    check({tag, ".hit"},   32'(resp_hit),   32'(exp_hit));
    check({tag, ".value"}, resp_value,      exp_val);
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_key      = '0;
    update_valid = 1'b0;
    update_key   = '0;
    update_value = '0;
    inval_valid  = 1'b0;
    inval_key    = '0;
    flush_valid  = 1'b0;

    // Reset state
    #12;
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_hit",   32'(resp_hit),   32'd0);
    check("rst.resp_value", resp_value,      32'd0);
    check("rst.flush_busy", 32'(flush_busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("rst.req_ready", 32'(req_ready), 32'd1);

    // Fill set 0 and look up
    do_update(32'h04, 32'hA);
    do_update(32'h08, 32'hB);
    lookup("lk04", 32'h04, 1'b1, 32'hA);
    lookup("lk08", 32'h08, 1'b1, 32'hB);
    lookup("lk0C_miss", 32'h0C, 1'b0, 32'h0);

    // Round-robin eviction: way0 goes first, then way1
    do_update(32'h0C, 32'hC);
    do_update(32'h10, 32'hD);
    lookup("ev04_miss", 32'h04, 1'b0, 32'h0);
    lookup("ev0C_hit",  32'h0C, 1'b1, 32'hC);
    lookup("ev08_miss", 32'h08, 1'b0, 32'h0);
    lookup("ev10_hit",  32'h10, 1'b1, 32'hD);

    // Overwrite leaves the pointer (still 0) alone, so 0x14 evicts way0 (0x0C)
    do_update(32'h0C, 32'hE);
    lookup("ow0C", 32'h0C, 1'b1, 32'hE);
    do_update(32'h14, 32'h14);
    lookup("ow0C_evicted", 32'h0C, 1'b0, 32'h0);
    lookup("ow14_hit",     32'h14, 1'b1, 32'h14);
    lookup("ow10_kept",    32'h10, 1'b1, 32'hD);

    // A cycle with no request holds the last result
    tick();
    check("hold.valid", 32'(resp_valid), 32'd0);
    check("hold.hit",   32'(resp_hit),   32'd1);
    check("hold.value", resp_value,      32'hD);

    // Another set, then invalidate
    do_update(32'h01, 32'h11);
    lookup("set1_hit", 32'h01, 1'b1, 32'h11);
    do_inval(32'h10);
    lookup("inv10_miss", 32'h10, 1'b0, 32'h0);
    lookup("inv14_kept", 32'h14, 1'b1, 32'h14);

    // The freed way1 is used without moving the pointer (1); the next
    // allocation then evicts way1 and the pointer wraps to 0.
    do_update(32'h18, 32'h18);
    do_update(32'h1C, 32'h1C);
    lookup("free14_kept",  32'h14, 1'b1, 32'h14);
    lookup("free18_evict", 32'h18, 1'b0, 32'h0);
    lookup("free1C_hit",   32'h1C, 1'b1, 32'h1C);

    // Flush: busy for exactly 4 cycles. Requests, updates and repeated
    // flush_valid are ignored while it runs.
    flush_valid = 1'b1;
    tick();
    check("fl.busy0",  32'(flush_busy), 32'd1);
    check("fl.ready0", 32'(req_ready),  32'd0);
    req_valid    = 1'b1;
    req_key      = 32'h14;
    update_valid = 1'b1;
    update_key   = 32'h02;
    update_value = 32'h99;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("fl.resp_valid%0d", i), 32'(resp_valid), 32'd0);
      check($sformatf("fl.busy%0d", i),  32'(flush_busy), (i < 4) ? 32'd1 : 32'd0);
      check($sformatf("fl.ready%0d", i), 32'(req_ready),  (i < 4) ? 32'd0 : 32'd1);
    end
    flush_valid  = 1'b0;
    req_valid    = 1'b0;
    update_valid = 1'b0;
    lookup("pf04", 32'h04, 1'b0, 32'h0);
    lookup("pf14", 32'h14, 1'b0, 32'h0);
    lookup("pf1C", 32'h1C, 1'b0, 32'h0);
    lookup("pf01", 32'h01, 1'b0, 32'h0);
    lookup("pf02_dropped", 32'h02, 1'b0, 32'h0);

    // Same cycle: update and invalidate of 0x05, plus a lookup of 0x05
    update_valid = 1'b1; update_key = 32'h05; update_value = 32'h7;
    inval_valid  = 1'b1; inval_key  = 32'h05;
    req_valid    = 1'b1; req_key    = 32'h05;
    tick();
    update_valid = 1'b0; inval_valid = 1'b0; req_valid = 1'b0;
    check("sc05.valid", 32'(resp_valid), 32'd1);
    check("sc05.hit",   32'(resp_hit),   BYPASS ? 32'd1 : 32'd0);
    check("sc05.value", resp_value,      BYPASS ? 32'h7 : 32'h0);
    lookup("sc05_after", 32'h05, 1'b1, 32'h7);

    // Same cycle: invalidate of 0x06 plus a lookup of 0x06
    do_update(32'h06, 32'h66);
    inval_valid = 1'b1; inval_key = 32'h06;
    req_valid   = 1'b1; req_key   = 32'h06;
    tick();
    inval_valid = 1'b0; req_valid = 1'b0;
    check("si06.hit",   32'(resp_hit), BYPASS ? 32'd0 : 32'd1);
    check("si06.value", resp_value,    BYPASS ? 32'h0 : 32'h66);
    lookup("si06_after", 32'h06, 1'b0, 32'h0);

    // Update and invalidate in different sets in the same cycle: both happen
    update_valid = 1'b1; update_key = 32'h03; update_value = 32'h33;
    inval_valid  = 1'b1; inval_key  = 32'h05;
    tick();
    update_valid = 1'b0; inval_valid = 1'b0;
    lookup("ds03_hit",  32'h03, 1'b1, 32'h33);
    lookup("ds05_miss", 32'h05, 1'b0, 32'h0);
    do_update(32'h07, 32'h77);
    lookup("pre07_hit", 32'h07, 1'b1, 32'h77);

    // Reset two cycles into a flush
    flush_valid = 1'b1;
    tick();
    flush_valid = 1'b0;
    tick();
    tick();
    check("mr.busy_before", 32'(flush_busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mr.busy",       32'(flush_busy), 32'd0);
    check("mr.resp_valid", 32'(resp_valid), 32'd0);
    check("mr.resp_hit",   32'(resp_hit),   32'd0);
    check("mr.resp_value", resp_value,      32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("mr.ready", 32'(req_ready), 32'd1);
    lookup("mr03", 32'h03, 1'b0, 32'h0);
    lookup("mr07", 32'h07, 1'b0, 32'h0);
    lookup("mr01", 32'h01, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
